inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Fetch-side initiator for the single-cycle instruction memory `inst_mem`, whose ports are `reset`, `PC[31:0]` and `op_code[31:0]`, with a combinational read.
- Owns the program counter and drives `PC`.
- Captures the returned `op_code` into an output register and hands instructions to decode over a valid/ready handshake.
- Handles back-pressure stalls, branch/jump redirects, end-of-memory and misaligned-target faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 32, instruction memory size in bytes. Valid fetch PCs are 0..MEM_BYTES-4, word aligned.
- HALT_OPCODE, 32'hFFFF_FFFF, encoding treated as halt. Used only when FETCH_HALT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pc_out  output  32  fetch address, connects to inst_mem.PC.
- op_code  input  32  instruction word from inst_mem, valid in the same cycle as pc_out.
- inst_out  output  32  registered instruction to decode.
- inst_pc  output  32  PC of inst_out.
- inst_valid  output  1  inst_out/inst_pc hold a live instruction.
- inst_ready  input  1  decode accepts this cycle.
- redirect_valid  input  1  branch/jump taken.
- redirect_pc  input  32  redirect target.
- fetch_done  output  1  sequential fetch ran past memory end (or halt); no further fetch.
- fault  output  1  sticky misaligned redirect target.

Behaviour:
- Reset (synchronous, active-high), on a clk edge with reset=1:
  - pc_out=RESET_PC; inst_out=0, inst_pc=0, inst_valid=0, fetch_done=0, fault=0.
  - state=WAIT.
  - Reset overrides every other input, including mid-stall and in FAULT.
- States: WAIT, FETCH, DONE, FAULT.
- WAIT:
  - One bubble cycle after reset deasserts; inst_mem may still be clearing.
  - No capture; next state is FETCH.
  - A redirect in WAIT is honoured: the pc update applies as in FETCH.
- FETCH, slot-free rule: the slot is free when inst_valid=0 OR (inst_valid & inst_ready).
- FETCH, priority in each cycle:
  1. redirect_valid=1:
     - If redirect_pc[1:0]!=0 or redirect_pc>=MEM_BYTES: go to FAULT, fault=1, inst_valid=0.
     - Else: pc_out<=redirect_pc and inst_valid<=0 (flush the slot, including an unconsumed one). No capture this cycle.
  2. Slot free:
     - inst_out<=op_code, inst_pc<=pc_out, inst_valid<=1.
     - If pc_out+4>=MEM_BYTES: state<=DONE and pc_out holds. Else pc_out<=pc_out+4.
  3. Otherwise (stall): pc_out, inst_out, inst_pc and inst_valid hold unchanged.
- Throughput and latency:
  - One instruction per cycle while inst_ready=1.
  - Latency from a pc_out value to inst_valid is 1 cycle.
- DONE:
  - fetch_done=1; no capture.
  - inst_valid clears once the last instruction is accepted.
  - A valid redirect returns to FETCH, clears fetch_done and loads pc_out.
  - An invalid redirect goes to FAULT.
- FAULT:
  - fault=1 and inst_valid=0; ignores all inputs except reset.
  - pc_out holds its last value.
- Arithmetic: 32-bit unsigned. pc_out+4 is never allowed to wrap, because of the DONE guard.
- inst_out/inst_pc must not change while inst_valid=1 and inst_ready=0.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - A captured op_code equal to HALT_OPCODE is delivered normally, with inst_valid=1.
  - The same edge moves the state to DONE (fetch_done=1) and pc_out stops advancing.
  - A valid redirect resumes fetching.
- Undefined: HALT_OPCODE is an ordinary instruction; no halt detection logic is generated.

Test Plan:
1. Memory words 0..28 preloaded with 32'h1000_0000+n. Pulse reset for 1 cycle, hold inst_ready=1.
   -> inst_valid rises 2 cycles after reset falls.
   -> inst_pc runs 0,4,...,28 with inst_out 32'h1000_0000..32'h1000_0007.
   -> fetch_done=1 after PC 28 is captured; inst_valid=0 the cycle after acceptance.
2. Drop inst_ready for 3 cycles while inst_pc=8.
   -> inst_out/inst_pc/pc_out frozen (8/12).
   -> On release, PC 12 is delivered next with no skip or duplicate.
3. redirect_valid=1, redirect_pc=20 while inst_pc=4 is unaccepted.
   -> inst_valid=0 next cycle; the next delivered inst_pc=20, inst_out=32'h1000_0005.
4. redirect_pc=6 (misaligned), then redirect_pc=40 in a separate run (out of range).
   -> fault=1 and inst_valid=0, both sticky.
   -> Cleared only by reset, after which the first delivered inst_pc=0.
5. Assert reset while in stall (inst_valid=1, inst_ready=0).
   -> Next edge: all outputs at reset values, pc_out=0.
6. FETCH_HALT_EN defined, word 12 = 32'hFFFF_FFFF.
   -> PC 12 delivered, then fetch_done=1 and pc_out holds.
   -> A redirect to 0 resumes at PC 0.
   -> Without the macro, PC 16 follows PC 12.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch initiator: owns the PC, drives inst_mem and hands captured words to decode.
// Optional halt-opcode detection is enabled by defining FETCH_HALT_EN.
module inst_fetch #(
`ifdef FETCH_HALT_EN
    parameter logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF,
`endif
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_BYTES   = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] op_code,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_done,
    output logic        fault
);

    typedef enum logic [1:0] {StWait, StFetch, StDone, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        valid_q, valid_d;

    logic redirect_bad;
    logic slot_free;
    logic last_word;
    logic stop_fetch;

    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= MEM_BYTES);
    assign slot_free    = !valid_q || inst_ready;
    // The guard keeps pc_q + 4 from ever wrapping.
    assign last_word    = (pc_q + 32'd4) >= MEM_BYTES;

`ifdef FETCH_HALT_EN
    assign stop_fetch = last_word || (op_code == HALT_OPCODE);
`else
    assign stop_fetch = last_word;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;

        if (state_q != StFault && redirect_valid) begin
            // A redirect from any live state flushes the slot, even an unconsumed one.
            valid_d = 1'b0;
            if (redirect_bad) begin
                state_d = StFault;
            end else begin
                state_d = StFetch;
                pc_d    = redirect_pc;
            end
        end else begin
            case (state_q)
                StWait: begin
                    state_d = StFetch;
                end
                StFetch: begin
                    if (slot_free) begin
                        inst_d    = op_code;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        if (stop_fetch) begin
                            state_d = StDone;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end
                StDone: begin
                    if (valid_q && inst_ready) begin
                        valid_d = 1'b0;
                    end
                end
                StFault: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = StWait;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StWait;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    assign pc_out     = pc_q;
    assign inst_out   = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = valid_q;
    assign fetch_done = (state_q == StDone);
    assign fault      = (state_q == StFault);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a queue of expected accepted instructions is checked by a
// monitor on every valid&ready handshake; stimulus also checks state outputs directly.
module tb_inst_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] op_code;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_done;
    logic        fault;

    logic [31:0] mem [8];
    logic [63:0] exp_q [$];
    logic [63:0] mon_exp;
    int          vectors;
    int          miscompares;

    inst_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .pc_out        (pc_out),
        .op_code       (op_code),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_done    (fetch_done),
        .fault         (fault)
    );

    assign op_code = mem[pc_out[4:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back({pc, inst});
    endtask

    task automatic push_seq(input logic [31:0] pc);
        push_exp(pc, 32'h1000_0000 + (pc >> 2));
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        tick();
        check({name, "_pc_out"}, pc_out, 32'h0);
        check({name, "_inst_out"}, inst_out, 32'h0);
        check({name, "_inst_pc"}, inst_pc, 32'h0);
        check({name, "_inst_valid"}, {31'b0, inst_valid}, 32'h0);
        check({name, "_fetch_done"}, {31'b0, fetch_done}, 32'h0);
        check({name, "_fault"}, {31'b0, fault}, 32'h0);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every handshake must match the next expected instruction.
    always @(negedge clk) begin
        if (inst_valid && inst_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL accept_unexpected: got pc %h inst %h, expected none",
                         inst_pc, inst_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({inst_pc, inst_out} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL accept: got pc %h inst %h, expected pc %h inst %h",
                             inst_pc, inst_out, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + i;

        // Straight-line fetch to end of memory
        do_reset("t1_rst");
        for (int i = 0; i < 8; i++) push_seq(i * 4);
        tick();
        check("t1_bubble", {31'b0, inst_valid}, 32'h0);
        tick();
        check("t1_first_valid", {31'b0, inst_valid}, 32'h1);
        check("t1_first_pc", inst_pc, 32'h0);
        repeat (7) tick();
        check("t1_last_pc", inst_pc, 32'd28);
        check("t1_done", {31'b0, fetch_done}, 32'h1);
        check("t1_pc_hold", pc_out, 32'd28);
        tick();
        check("t1_valid_clear", {31'b0, inst_valid}, 32'h0);
        check("t1_done_stays", {31'b0, fetch_done}, 32'h1);
        check("t1_drained", exp_q.size(), 32'h0);

        // Redirect out of DONE resumes fetch
        redirect_valid = 1'b1;
        redirect_pc    = 32'd8;
        tick();
        redirect_valid = 1'b0;
        check("t1r_done_clr", {31'b0, fetch_done}, 32'h0);
        check("t1r_pc", pc_out, 32'd8);
        push_seq(32'd8);
        tick();
        check("t1r_inst_pc", inst_pc, 32'd8);

        // Back-pressure stall at inst_pc 8
        do_reset("t2_rst");
        for (int i = 0; i < 8; i++) push_seq(i * 4);
        repeat (4) tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_stall_pc", inst_pc, 32'd8);
            check("t2_stall_inst", inst_out, 32'h1000_0002);
            check("t2_stall_pcout", pc_out, 32'd12);
            check("t2_stall_valid", {31'b0, inst_valid}, 32'h1);
        end
        inst_ready = 1'b1;
        tick();
        check("t2_resume_pc", inst_pc, 32'd12);
        check("t2_resume_inst", inst_out, 32'h1000_0003);
        repeat (5) tick();
        check("t2_end_valid", {31'b0, inst_valid}, 32'h0);
        check("t2_drained", exp_q.size(), 32'h0);

        // Redirect flushes an unaccepted instruction
        do_reset("t3_rst");
        push_seq(32'd0);
        repeat (3) tick();
        check("t3_pending_pc", inst_pc, 32'd4);
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd20;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        check("t3_flush", {31'b0, inst_valid}, 32'h0);
        check("t3_pc", pc_out, 32'd20);
        push_seq(32'd20);
        push_seq(32'd24);
        push_seq(32'd28);
        tick();
        check("t3_new_pc", inst_pc, 32'd20);
        check("t3_new_inst", inst_out, 32'h1000_0005);
        repeat (3) tick();
        check("t3_done", {31'b0, fetch_done}, 32'h1);
        check("t3_drained", exp_q.size(), 32'h0);

        // Misaligned redirect faults, sticky until reset
        do_reset("t4a_rst");
        push_seq(32'd0);
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd6;
        tick();
        check("t4a_fault", {31'b0, fault}, 32'h1);
        check("t4a_valid", {31'b0, inst_valid}, 32'h0);
        check("t4a_pc_hold", pc_out, 32'd4);
        redirect_pc = 32'd8;
        repeat (3) tick();
        redirect_valid = 1'b0;
        check("t4a_sticky", {31'b0, fault}, 32'h1);
        check("t4a_pc_sticky", pc_out, 32'd4);
        check("t4a_valid_sticky", {31'b0, inst_valid}, 32'h0);
        do_reset("t4a_clr");
        push_seq(32'd0);
        repeat (2) tick();
        check("t4a_restart_pc", inst_pc, 32'd0);
        check("t4a_restart_valid", {31'b0, inst_valid}, 32'h1);

        // Out-of-range redirect faults
        do_reset("t4b_rst");
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd40;
        tick();
        redirect_valid = 1'b0;
        check("t4b_fault", {31'b0, fault}, 32'h1);
        check("t4b_valid", {31'b0, inst_valid}, 32'h0);
        tick();
        check("t4b_sticky", {31'b0, fault}, 32'h1);

        // Boundary: MEM_BYTES faults in WAIT, MEM_BYTES-4 is legal
        do_reset("t4c_rst");
        redirect_valid = 1'b1;
        redirect_pc    = 32'd32;
        tick();
        redirect_valid = 1'b0;
        check("t4c_fault32", {31'b0, fault}, 32'h1);
        do_reset("t4d_rst");
        redirect_valid = 1'b1;
        redirect_pc    = 32'd28;
        tick();
        redirect_valid = 1'b0;
        check("t4d_nofault", {31'b0, fault}, 32'h0);
        check("t4d_pc", pc_out, 32'd28);
        push_seq(32'd28);
        tick();
        check("t4d_inst_pc", inst_pc, 32'd28);
        check("t4d_done", {31'b0, fetch_done}, 32'h1);
        tick();
        check("t4d_valid_clr", {31'b0, inst_valid}, 32'h0);

        // Reset during a stall
        do_reset("t5_rst");
        repeat (2) tick();
        inst_ready = 1'b0;
        tick();
        check("t5_stall_valid", {31'b0, inst_valid}, 32'h1);
        check("t5_stall_pcout", pc_out, 32'd4);
        do_reset("t5_mid");
        inst_ready = 1'b1;

        // Halt opcode at PC 12
        mem[3] = 32'hFFFF_FFFF;
        do_reset("t6_rst");
        push_seq(32'd0);
        push_seq(32'd4);
        push_seq(32'd8);
        push_exp(32'd12, 32'hFFFF_FFFF);
        repeat (5) tick();
        check("t6_halt_pc", inst_pc, 32'd12);
        check("t6_halt_inst", inst_out, 32'hFFFF_FFFF);
`ifdef FETCH_HALT_EN
        check("t6_done", {31'b0, fetch_done}, 32'h1);
        check("t6_pc_hold", pc_out, 32'd12);
        tick();
        check("t6_valid_clr", {31'b0, inst_valid}, 32'h0);
        check("t6_pc_hold2", pc_out, 32'd12);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        tick();
        redirect_valid = 1'b0;
        check("t6_resume_done", {31'b0, fetch_done}, 32'h0);
        check("t6_resume_pcout", pc_out, 32'd0);
        push_seq(32'd0);
        tick();
        check("t6_resume_pc", inst_pc, 32'd0);
`else
        check("t6_not_done", {31'b0, fetch_done}, 32'h0);
        check("t6_pc_adv", pc_out, 32'd16);
        push_seq(32'd16);
        tick();
        check("t6_next_pc", inst_pc, 32'd16);
`endif
        do_reset("t6_end");
        mem[3] = 32'h1000_0003;
        check("final_drained", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
